// File: rtl/fmap_dpram_pkg.sv
// Shared types and helpers for the feature-map buffer and its clear engine.
package fmap_dpram_pkg;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

  // True when an address of addr_w bits can reach every one of depth words.
  function automatic bit addr_w_fits(input int unsigned depth, input int unsigned addr_w);
    return (longint'(1) << addr_w) >= longint'(depth);
  endfunction

  // Pad border of a channel plane: its last column and its last row.
  function automatic logic is_pad_pos(input int unsigned row, input int unsigned col,
                                      input int unsigned rows, input int unsigned cols);
    return (col == cols - 1) || (row == rows - 1);
  endfunction

endpackage

// File: rtl/fmap_dpram_if.sv
// Port A / port B / clear-request bundle of the feature-map buffer.
interface fmap_dpram_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic              a_en;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din;
  logic [DATA_W-1:0] a_dout;
  logic              b_en;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_din;
  logic [DATA_W-1:0] b_dout;
  logic              clr_req;
  logic              clr_full;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output a_en, a_we, a_addr, a_din,
    output b_en, b_we, b_addr, b_din,
    output clr_req, clr_full,
    input  a_dout, b_dout, clr_busy, clr_done
  );

  modport slave (
    input  a_en, a_we, a_addr, a_din,
    input  b_en, b_we, b_addr, b_din,
    input  clr_req, clr_full,
    output a_dout, b_dout, clr_busy, clr_done
  );
endinterface

// File: rtl/fmap_pad_clear.sv
// Clear engine: walks every address once (col, then row, then ch) and emits a
// zero-write for either the pad border or the whole array.
module fmap_pad_clear
  import fmap_dpram_pkg::*;
#(
  parameter int unsigned ROWS   = 9,
  parameter int unsigned COLS   = 9,
  parameter int unsigned CH     = 2,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr_req,
  input  logic              i_clr_full,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);

  clr_state_e        r_state, w_state_nxt;
  logic              r_full, w_full_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt;
  logic [ROW_W-1:0]  r_row, w_row_nxt;
  logic [COL_W-1:0]  r_col, w_col_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_done, w_done_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_full_nxt  = r_full;
    w_ch_nxt    = r_ch;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_addr_nxt  = r_addr;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      CLR_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLR_SWEEP;
          w_full_nxt  = i_clr_full;
          w_ch_nxt    = '0;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_addr_nxt  = '0;
        end
      end
      CLR_SWEEP: begin
        // Linear address tracks the (ch,row,col) nest so no multiplier is needed.
        w_addr_nxt = r_addr + 1'b1;
        if (r_col != COL_LAST) begin
          w_col_nxt = r_col + 1'b1;
        end else begin
          w_col_nxt = '0;
          if (r_row != ROW_LAST) begin
            w_row_nxt = r_row + 1'b1;
          end else begin
            w_row_nxt = '0;
            if (r_ch != CH_LAST) begin
              w_ch_nxt = r_ch + 1'b1;
            end else begin
              w_ch_nxt    = '0;
              w_addr_nxt  = '0;
              w_state_nxt = CLR_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = CLR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLR_IDLE;
      r_full  <= 1'b0;
      r_ch    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= w_full_nxt;
      r_ch    <= w_ch_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_addr  <= w_addr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_busy = (r_state == CLR_SWEEP);
  assign o_we   = o_busy & (r_full | is_pad_pos(32'(r_row), 32'(r_col), ROWS, COLS));
  assign o_addr = r_addr;
  assign o_done = r_done;

endmodule

// File: rtl/fmap_dpram.sv
// True dual-port read-first feature-map buffer (CH x ROWS x COLS words).
// Optional pad/full clear engine on port B, built when FMAP_DPRAM_CLEAR_EN is defined.
module fmap_dpram
  import fmap_dpram_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ROWS   = 9,
  parameter int unsigned COLS   = 9,
  parameter int unsigned CH     = 2,
  parameter int unsigned ADDR_W = 10
) (
  input logic           clk,
  input logic           rst,
  fmap_dpram_if.slave   bus
);

  localparam int unsigned      DEPTH   = ROWS * COLS * CH;
  localparam int unsigned      IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W + 1)'(DEPTH);

  if (!addr_w_fits(DEPTH, ADDR_W)) begin : g_bad_addr_w
    $error("fmap_dpram: ADDR_W cannot address ROWS*COLS*CH words");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_a_dout, r_b_dout;

  logic              w_eng_busy, w_eng_done, w_eng_we;
  logic [ADDR_W-1:0] w_eng_addr;

`ifdef FMAP_DPRAM_CLEAR_EN
  fmap_pad_clear #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .CH     (CH),
    .ADDR_W (ADDR_W)
  ) u_pad_clear (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr_req  (bus.clr_req),
    .i_clr_full (bus.clr_full),
    .o_busy     (w_eng_busy),
    .o_done     (w_eng_done),
    .o_we       (w_eng_we),
    .o_addr     (w_eng_addr)
  );
`else
  logic w_clr_unused;
  assign w_clr_unused = bus.clr_req ^ bus.clr_full;
  assign w_eng_busy   = 1'b0;
  assign w_eng_done   = 1'b0;
  assign w_eng_we     = 1'b0;
  assign w_eng_addr   = '0;
`endif

  logic             w_a_ok, w_b_ok;
  logic [IDX_W-1:0] w_a_idx, w_b_ext_idx, w_b_idx;
  logic             w_a_wr, w_b_wr_ext, w_a_wr_eff, w_b_wr;
  logic [DATA_W-1:0] w_b_wdata;

  assign w_a_ok      = {1'b0, bus.a_addr} < DEPTH_X;
  assign w_b_ok      = {1'b0, bus.b_addr} < DEPTH_X;
  assign w_a_idx     = bus.a_addr[IDX_W-1:0];
  assign w_b_ext_idx = bus.b_addr[IDX_W-1:0];

  assign w_a_wr     = bus.a_en & bus.a_we & w_a_ok;
  assign w_b_wr_ext = ~w_eng_busy & bus.b_en & bus.b_we & w_b_ok;

  // Same-address collisions: engine zero beats port A, port A beats external port B.
  assign w_a_wr_eff = w_a_wr & ~(w_eng_we & (w_eng_addr == bus.a_addr));
  assign w_b_wr     = w_eng_busy ? w_eng_we
                                 : (w_b_wr_ext & ~(w_a_wr & (bus.a_addr == bus.b_addr)));
  assign w_b_idx    = w_eng_busy ? w_eng_addr[IDX_W-1:0] : w_b_ext_idx;
  assign w_b_wdata  = w_eng_busy ? '0 : bus.b_din;

  always_ff @(posedge clk) begin
    if (w_a_wr_eff) r_mem[w_a_idx] <= bus.a_din;
    if (w_b_wr)     r_mem[w_b_idx] <= w_b_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_dout <= '0;
      r_b_dout <= '0;
    end else begin
      if (bus.a_en) r_a_dout <= w_a_ok ? r_mem[w_a_idx] : '0;
      if (bus.b_en && !w_eng_busy) r_b_dout <= w_b_ok ? r_mem[w_b_ext_idx] : '0;
    end
  end

  assign bus.a_dout   = r_a_dout;
  assign bus.b_dout   = r_b_dout;
  assign bus.clr_busy = w_eng_busy;
  assign bus.clr_done = w_eng_done;

endmodule

// File: tb/tb_fmap_dpram.sv
// Randomized bench for fmap_dpram against a word-array reference model.
module tb_fmap_dpram;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ROWS    = 9;
  localparam int unsigned COLS    = 9;
  localparam int unsigned CH      = 2;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned PLANE   = ROWS * COLS;
  localparam int unsigned DEPTH   = PLANE * CH;
  localparam int unsigned TIMEOUT = DEPTH + 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fmap_dpram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fmap_dpram #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .CH     (CH),
    .ADDR_W (ADDR_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_a, exp_b;
  int unsigned       n_checks = 0;
  int unsigned       n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pad_pos(input int unsigned addr);
    int unsigned off;
    off = addr % PLANE;
    return ((off % COLS) == COLS - 1) || ((off / COLS) == ROWS - 1);
  endfunction

  // Drive both ports and advance the model; b_live=0 means the engine owns port B.
  task automatic drive_ports(input logic ae, input logic awe, input int unsigned aa,
                             input logic [DATA_W-1:0] ad, input logic be, input logic bwe,
                             input int unsigned ba, input logic [DATA_W-1:0] bd,
                             input bit b_live);
    bus.a_en = ae;  bus.a_we = awe;  bus.a_addr = ADDR_W'(aa);  bus.a_din = ad;
    bus.b_en = be;  bus.b_we = bwe;  bus.b_addr = ADDR_W'(ba);  bus.b_din = bd;
    if (ae) exp_a = (aa < DEPTH) ? model[aa] : '0;
    if (b_live && be) exp_b = (ba < DEPTH) ? model[ba] : '0;
    if (b_live && be && bwe && ba < DEPTH) model[ba] = bd;
    if (ae && awe && aa < DEPTH) model[aa] = ad;
  endtask

  task automatic port_op(input logic ae, input logic awe, input int unsigned aa,
                         input logic [DATA_W-1:0] ad, input logic be, input logic bwe,
                         input int unsigned ba, input logic [DATA_W-1:0] bd, input bit do_chk);
    drive_ports(ae, awe, aa, ad, be, bwe, ba, bd, 1'b1);
    tick();
    if (do_chk) begin
      check("a_dout", bus.a_dout, exp_a);
      check("b_dout", bus.b_dout, exp_b);
    end
  endtask

  task automatic rand_op(input bit do_chk);
    port_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH + 13),
            DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, DEPTH + 13), DATA_W'($urandom), do_chk);
  endtask

  task automatic readback();
    for (int a = 0; a < DEPTH; a++) begin
      drive_ports(1'b1, 1'b0, a, '0, 1'b0, 1'b0, 0, '0, 1'b1);
      tick();
      check($sformatf("rd%0d", a), bus.a_dout, exp_a);
    end
  endtask

  task automatic fill_incr();
    for (int a = 0; a < DEPTH; a += 2)
      port_op(1'b1, 1'b1, a, DATA_W'(a + 1), 1'b1, 1'b1, a + 1, DATA_W'(a + 2), 1'b1);
  endtask

`ifdef FMAP_DPRAM_CLEAR_EN
  task automatic run_clear(input bit full, input int rst_at);
    fill_incr();
    drive_ports(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0, 1'b1);
    bus.clr_req  = 1'b1;
    bus.clr_full = full;
    tick();
    bus.clr_req  = 1'b0;
    bus.clr_full = ~full;
    for (int k = 0; k < DEPTH; k++) begin
      check("busy", bus.clr_busy, 1);
      check("done_early", bus.clr_done, 0);
      if (k == rst_at) begin
        drive_ports(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        exp_a = '0;
        exp_b = '0;
        check("busy_after_rst", bus.clr_busy, 0);
        check("done_after_rst", bus.clr_done, 0);
        check("a_dout_rst", bus.a_dout, exp_a);
        // Whether word k was zeroed on the reset edge is not pinned down; rewrite it.
        port_op(1'b1, 1'b1, k, 16'h00C3, 1'b0, 1'b0, 0, '0, 1'b0);
        port_op(1'b1, 1'b0, 0, '0, 1'b1, 1'b0, 0, '0, 1'b0);
        for (int j = 0; j < 5; j++) begin
          port_op(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0, 1'b1);
          check("no_done_rst", bus.clr_done, 0);
        end
        readback();
        return;
      end
      drive_ports(1'(rst_at < 0 && $urandom_range(0, 1) == 1),
                  1'(rst_at < 0 && $urandom_range(0, 2) == 0),
                  $urandom_range(0, DEPTH + 13), DATA_W'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, DEPTH - 1), DATA_W'($urandom | 1), 1'b0);
      if (full || pad_pos(k)) model[k] = '0;
      tick();
      check("a_dout_sweep", bus.a_dout, exp_a);
      check("b_dout_hold", bus.b_dout, exp_b);
    end
    check("done", bus.clr_done, 1);
    check("busy_end", bus.clr_busy, 0);
    port_op(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0, 1'b1);
    check("done_once", bus.clr_done, 0);
    readback();
  endtask

  task automatic run_back_to_back();
    int n;
    fill_incr();
    drive_ports(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0, 1'b1);
    bus.clr_req  = 1'b1;
    bus.clr_full = 1'b1;
    n = 0;
    while (!bus.clr_done && n < TIMEOUT) begin
      tick();
      n++;
    end
    check("b2b_first_done", n, DEPTH + 1);
    tick();
    check("b2b_rebusy", bus.clr_busy, 1);
    bus.clr_req = 1'b0;
    n = 0;
    while (!bus.clr_done && n < TIMEOUT) begin
      tick();
      n++;
    end
    check("b2b_second_done", n, DEPTH);
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    tick();
    readback();
  endtask
`endif

  initial begin
    bus.clr_req  = 1'b0;
    bus.clr_full = 1'b0;
    drive_ports(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0, 1'b0);
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_a_dout", bus.a_dout, 0);
    check("rst_b_dout", bus.b_dout, 0);
    check("rst_busy", bus.clr_busy, 0);
    check("rst_done", bus.clr_done, 0);
    rst   = 1'b0;
    exp_a = '0;
    exp_b = '0;

    // Contents at power-up are not relied on: write every word, then resync expectations.
    for (int a = 0; a < DEPTH; a += 2)
      port_op(1'b1, 1'b1, a, DATA_W'($urandom), 1'b1, 1'b1, a + 1, DATA_W'($urandom), 1'b0);
    port_op(1'b1, 1'b0, 0, '0, 1'b1, 1'b0, 1, '0, 1'b0);

    port_op(1'b1, 1'b1, 40, 16'h0000, 1'b0, 1'b0, 0, '0, 1'b1);
    port_op(1'b1, 1'b1, 40, 16'h1234, 1'b0, 1'b0, 0, '0, 1'b1);
    check("a_read_first", bus.a_dout, 16'h0000);
    port_op(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 40, '0, 1'b1);
    check("b_sees_a_write", bus.b_dout, 16'h1234);

    port_op(1'b1, 1'b1, 5, 16'hAAAA, 1'b1, 1'b1, 5, 16'h5555, 1'b1);
    port_op(1'b1, 1'b0, 5, '0, 1'b1, 1'b0, 5, '0, 1'b1);
    check("collide_a_wins", bus.a_dout, 16'hAAAA);

    port_op(1'b1, 1'b1, 170, 16'hBEEF, 1'b1, 1'b1, 170, 16'hCAFE, 1'b1);
    check("oor_a_zero", bus.a_dout, 0);

    for (int i = 0; i < 400; i++) rand_op(1'b1);
    readback();

`ifdef FMAP_DPRAM_CLEAR_EN
    run_clear(1'b0, -1);
    run_clear(1'b1, -1);
    run_clear(1'b1, 50);
    run_back_to_back();
`else
    bus.clr_req  = 1'b1;
    bus.clr_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_op(1'b1);
      check("noeng_busy", bus.clr_busy, 0);
      check("noeng_done", bus.clr_done, 0);
    end
    bus.clr_req = 1'b0;
    readback();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fmap_dpram.md
# fmap_dpram

Parametrised single-clock true dual-port feature-map buffer for the 2D stride-2 convolution datapath: CH channels of ROWS x COLS words, each port independently reading/writing with read-first semantics. It adds a hardware clear engine that zeroes either the padding border (last column and last row of every channel) or the whole array on request, so conv layers can reuse the buffer between passes without software scrubbing. It sits between the input-tile loader (port A) and the conv window fetch (port B).

## Interface
- DATA_W, 16, word width
- ROWS, 9, rows per channel (incl. pad row)
- COLS, 9, columns per channel (incl. pad column)
- CH, 2, channel count
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= ROWS*COLS*CH

- clk  in  1  single clock, all logic posedge
- rst  in  1  synchronous, active-high reset
- a_en  in  1  port A enable
- a_we  in  1  port A write enable (qualified by a_en)
- a_addr  in  ADDR_W  port A address
- a_din  in  DATA_W  port A write data
- a_dout  out  DATA_W  port A registered read data
- b_en, b_we, b_addr, b_din, b_dout  same as port A, for port B
- clr_req  in  1  start clear (level sampled)
- clr_full  in  1  sampled with clr_req: 1 = zero all, 0 = zero pad border only
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse on clear completion

## Operation
- DEPTH = ROWS*COLS*CH; address = ch*ROWS*COLS + row*COLS + col.
- Array initialised to zero at configuration; rst does not clear array contents.
- Port access (en=1): if we, write din; dout <= old contents (read-first) in both cases. en=0: dout holds.
- Address >= DEPTH: write dropped, dout <= 0.
- Both ports write same address same cycle: port A data stored; both douts return old contents.
- Clear FSM: IDLE -> SWEEP -> IDLE. In IDLE, clr_req=1 latches clr_full, loads counters to (ch,row,col)=(0,0,0), enters SWEEP.
- SWEEP visits every address once, one per cycle, col fastest then row then ch. Writes zero if clr_full, or if col==COLS-1 or row==ROWS-1; else no write. Exits after address DEPTH-1, pulses clr_done.
- During SWEEP the engine owns port B: external b_en/b_we ignored, b_dout holds. Port A stays live; A write colliding with engine write on same address: zero (engine) wins.
- clr_req while busy: ignored, not queued.
- rst mid-SWEEP: FSM to IDLE, counters cleared, partially cleared array left as-is, no clr_done.

## Timing
- Reset values: a_dout=0, b_dout=0, clr_busy=0, clr_done=0, FSM IDLE.
- Read latency 1 cycle: address at edge N, data valid after edge N+1.
- Write visible to either port's read issued at edge N+1 or later.
- clr_req high at edge N (IDLE): clr_busy high from N+1 for exactly DEPTH cycles; first engine write at edge N+1; clr_done high for the single cycle after the last write, clr_busy low in that same cycle.
- Back-to-back: clr_req held high re-triggers at the clr_done cycle edge; busy reasserts one cycle after done.
- Total clear cost is always DEPTH cycles, independent of clr_full.

## Configuration
- FMAP_DPRAM_CLEAR_EN defined: clear engine and port-B arbitration built as above.
- Undefined: engine omitted; clr_req/clr_full ignored, clr_busy and clr_done tied 0, port B always external.

## Structure
- Package fmap_dpram_pkg: clear FSM state enum (CLR_IDLE, CLR_SWEEP), depth/address-width check function, pad-position predicate.
- Sub-module fmap_pad_clear: FSM, ch/row/col counters, emits engine address/write-enable/busy/done; top holds array, port muxing, collision rule.

## Test plan
- Defaults: A writes 0x1234 at 40, B reads 40 next cycle -> b_dout=0x1234 one cycle later; A read same cycle as own write returns prior 0x0000.
- Both ports write addr 5 (A=0xAAAA, B=0x5555) -> subsequent read 5 = 0xAAAA.
- Fill all 162 words with addr+1, clr_req, clr_full=0 -> busy 162 cycles, done pulse once; addresses 8,17,...,80,72..80,89,...,161 read 0, address 0 reads 1, address 81 reads 82.
- Same fill, clr_full=1 -> all 162 read 0; b_we pulses during busy have no effect.
- rst asserted 50 cycles into sweep -> busy=0 next cycle, no done, address 80 retains nonzero fill.
- Write/read address 170 (>= DEPTH) -> no array change, dout=0.
